// File: rtl/im_loader_pkg.sv
// Shared types and default geometry for the instruction-memory loader and the fetch unit.
package im_loader_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned IM_DATA_W = 13;
  localparam int unsigned IM_ADDR_W = 5;
  localparam int unsigned IM_DEPTH  = 32;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StHi,
    StLo,
    StWrite,
    StCksum,
    StFinish,
    StError
  } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Host byte link plus instruction-memory write port; slave is the loader, master the host side.
interface im_loader_if #(
  parameter int unsigned DATA_W = im_loader_pkg::IM_DATA_W,
  parameter int unsigned ADDR_W = im_loader_pkg::IM_ADDR_W
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              write_enable;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output write_enable,
    output write_address,
    output write_data
  );

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  write_enable,
    input  write_address,
    input  write_data
  );
endinterface

// File: rtl/im_loader.sv
// Loads the instruction memory from a byte stream, two bytes per word, holding the core meanwhile.
// Define IM_LOADER_CKSUM_EN to require a trailing XOR checksum byte over all instruction bytes.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int unsigned DATA_W = IM_DATA_W,
  parameter int unsigned ADDR_W = IM_ADDR_W,
  parameter int unsigned DEPTH  = IM_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  im_loader_if.slave  bus,
  output logic        core_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-9:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                err_q, err_d;
`ifdef IM_LOADER_CKSUM_EN
  logic [BYTE_W-1:0]   cksum_q, cksum_d;
`endif
  logic                rx_ready;
  logic                accept;

  always_comb begin
    rx_ready = 1'b0;
    unique case (state_q)
      StCount, StHi, StLo: rx_ready = 1'b1;
`ifdef IM_LOADER_CKSUM_EN
      StCksum:             rx_ready = 1'b1;
`endif
      default:             rx_ready = 1'b0;
    endcase
  end

  assign accept = bus.rx_valid && rx_ready;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    hold_d    = hold_q;
    err_d     = err_q;
`ifdef IM_LOADER_CKSUM_EN
    cksum_d   = cksum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCount;
          busy_d  = 1'b1;
          hold_d  = 1'b1;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d = '0;
`endif
        end
      end
      StCount: begin
        if (accept) begin
          if (bus.rx_data != '0 && 32'(bus.rx_data) <= DEPTH) begin
            // Store N-1 so the last-word test is a plain equality on the counter.
            last_d  = ADDR_W'(bus.rx_data - 8'd1);
            state_d = StHi;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      StHi: begin
        if (accept) begin
          hi_d    = bus.rx_data[DATA_W-9:0];
          state_d = StLo;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d = cksum_q ^ bus.rx_data;
`endif
        end
      end
      StLo: begin
        if (accept) begin
          wr_data_d = {hi_q, bus.rx_data};
          wr_addr_d = cnt_q;
          state_d   = StWrite;
`ifdef IM_LOADER_CKSUM_EN
          cksum_d   = cksum_q ^ bus.rx_data;
`endif
        end
      end
      StWrite: begin
        if (cnt_q == last_q) begin
`ifdef IM_LOADER_CKSUM_EN
          state_d = StCksum;
`else
          state_d = StFinish;
          busy_d  = 1'b0;
          hold_d  = 1'b0;
`endif
        end else begin
          cnt_d   = cnt_q + ADDR_W'(1);
          state_d = StHi;
        end
      end
`ifdef IM_LOADER_CKSUM_EN
      StCksum: begin
        if (accept) begin
          if (bus.rx_data == cksum_q) begin
            state_d = StFinish;
            busy_d  = 1'b0;
            hold_d  = 1'b0;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
`endif
      StFinish: state_d = StIdle;
      StError:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      last_q    <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
`ifdef IM_LOADER_CKSUM_EN
      cksum_q   <= cksum_d;
`endif
    end
  end

  assign bus.rx_ready      = rx_ready;
  assign bus.write_enable  = (state_q == StWrite);
  assign bus.write_address = wr_addr_q;
  assign bus.write_data    = wr_data_q;
  assign done              = (state_q == StFinish);
  assign busy              = busy_q;
  assign core_hold         = hold_q;
  assign err               = err_q;

endmodule
